// File: rtl/bit_adj_16b_to_32b_pkg.sv
// Shared constants and types for the 16-bit to 32-bit sample widening stage.
// The 32-bit layout is sign guard bits, the 16-bit value, then zero fraction bits.
package bit_adj_16b_to_32b_pkg;

    localparam int DATA_W_NARROW = 16;
    localparam int DATA_W_WIDE   = 32;
    localparam int FRAC_SHIFT    = 12;
    localparam int GUARD_BITS    = 4;
    localparam int FFT_POINTS    = 64;
    localparam int IDX_W         = 6;

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(FFT_POINTS - 1);

    typedef struct packed {
        logic [DATA_W_WIDE-1:0] re;
        logic [DATA_W_WIDE-1:0] im;
        logic [IDX_W-1:0]       index;
        logic                   last;
    } out_sample_t;

endpackage

// File: rtl/bit_adj_16b_to_32b_widen.sv
// Widens one signed 16-bit component into the 32-bit word layout used by the
// 32-to-16 reducer: sign-extended guard bits on top, zero fraction bits below.
module bit_widen_16b_to_32b
    import bit_adj_16b_to_32b_pkg::*;
(
    input  logic [DATA_W_NARROW-1:0] i_data,
    output logic [DATA_W_WIDE-1:0]   o_data
);

    assign o_data = {{GUARD_BITS{i_data[DATA_W_NARROW-1]}}, i_data, {FRAC_SHIFT{1'b0}}};

endmodule

// File: rtl/bit_adj_16b_to_32b.sv
// Single registered valid/ready stage that widens complex 16-bit samples to
// 32 bits and tags each accepted sample with its point index in a 64-point frame.
module bit_adj_16b_to_32b
    import bit_adj_16b_to_32b_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W_NARROW-1:0] i_re,
    input  logic [DATA_W_NARROW-1:0] i_im,
    input  logic                     i_frame_start,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_W_WIDE-1:0]   o_re,
    output logic [DATA_W_WIDE-1:0]   o_im,
    output logic [IDX_W-1:0]         o_index,
    output logic                     o_last
);

    logic [DATA_W_WIDE-1:0] re_wide;
    logic [DATA_W_WIDE-1:0] im_wide;

    bit_widen_16b_to_32b u_widen_re (.i_data(i_re), .o_data(re_wide));
    bit_widen_16b_to_32b u_widen_im (.i_data(i_im), .o_data(im_wide));

    out_sample_t      out_q, out_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             in_xfer;
    logic             out_xfer;
    logic [IDX_W-1:0] next_index;

    // The stage can take a new sample whenever its slot is empty or being drained.
    assign o_ready  = !valid_q || i_ready;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = valid_q && i_ready;

    assign next_index = i_frame_start ? '0 : cnt_q;

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        out_d   = out_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (in_xfer) begin
            out_d.re    = re_wide;
            out_d.im    = im_wide;
            out_d.index = next_index;
            out_d.last  = (next_index == LAST_INDEX);
            valid_d     = 1'b1;
            cnt_d       = next_index + IDX_W'(1);
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data registers are reset as well because the outputs must read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid = valid_q;
    assign o_re    = out_q.re;
    assign o_im    = out_q.im;
    assign o_index = out_q.index;
    assign o_last  = out_q.last;

endmodule

// File: tb/tb_bit_adj_16b_to_32b.sv
// Randomised scoreboard bench for bit_adj_16b_to_32b: a driver pushes the expected
// response of every accepted sample, a negedge monitor pops and compares outputs.
module tb_bit_adj_16b_to_32b;
    import bit_adj_16b_to_32b_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_re = '0;
    logic [15:0] i_im = '0;
    logic        i_frame_start = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_re;
    logic [31:0] o_im;
    logic [5:0]  o_index;
    logic        o_last;

    bit_adj_16b_to_32b dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_re(i_re), .i_im(i_im), .i_frame_start(i_frame_start),
        .o_valid(o_valid), .i_ready(i_ready), .o_re(o_re), .o_im(o_im),
        .o_index(o_index), .o_last(o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   model_pos = 0;     // position the next non-frame-start sample takes
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] widen_model(input logic [15:0] v);
        int s;
        s = int'($signed(v)) * 4096;
        return 32'(s);
    endfunction

    // Downstream 32-to-16 reducer: drop the fraction bits, keep the 16-bit value.
    function automatic logic [15:0] reduce_model(input logic [31:0] w);
        return 16'($signed(w) >>> FRAC_SHIFT);
    endfunction

    // Backpressure generator, settled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Called at posedge+1; leaves at posedge+1 with the inputs still driven.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic fs);
        exp_t e;
        int   waited;
        i_valid = 1'b1;
        i_re = re;
        i_im = im;
        i_frame_start = fs;
        waited = 0;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            waited++;
            if (waited > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: o_ready stuck 0 for %0d cycles, expected 1", waited);
                break;
            end
            @(posedge clk);
            #1;
        end
        e.re = re;
        e.im = im;
        e.idx = fs ? 0 : model_pos;
        model_pos = (e.idx + 1) % FFT_POINTS;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        sb.delete();
        model_pos = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks held outputs.
    logic        prev_stall = 1'b0;
    logic [31:0] held_re, held_im;
    logic [5:0]  held_idx;
    logic        held_last;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (o_valid && !i_ready) check("o_ready_stall", 32'(o_ready), 32'd0);
            if (prev_stall) begin
                check("hold_re", o_re, held_re);
                check("hold_im", o_im, held_im);
                check("hold_index", 32'(o_index), 32'(held_idx));
                check("hold_last", 32'(o_last), 32'(held_last));
            end
            prev_stall = o_valid && !i_ready;
            held_re = o_re;
            held_im = o_im;
            held_idx = o_index;
            held_last = o_last;
            if (o_valid && i_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: index %0d with nothing expected", o_index);
                end else begin
                    e = sb.pop_front();
                    check("o_re", o_re, widen_model(e.re));
                    check("o_im", o_im, widen_model(e.im));
                    check("o_index", 32'(o_index), 32'(e.idx));
                    check("o_last", 32'(o_last), (e.idx == FFT_POINTS - 1) ? 32'd1 : 32'd0);
                    check("reduced_re", 32'(reduce_model(o_re)), 32'(e.re));
                    check("reduced_im", 32'(reduce_model(o_im)), 32'(e.im));
                end
            end
        end
    end

    initial begin
        int waited;
        // Reset state
        #12;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_re", o_re, 32'd0);
        check("rst_o_index", 32'(o_index), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        apply_reset();
        check("ready_after_reset", 32'(o_ready), 32'd1);

        // Extreme values with frame start
        send(16'h7FFF, 16'h8000, 1'b1);
        check("first_o_valid", 32'(o_valid), 32'd1);
        check("first_o_re", o_re, 32'h07FFF000);
        check("first_o_im", o_im, 32'hF8000000);
        check("first_o_index", 32'(o_index), 32'd0);
        idle(2);

        // Full frame plus one, including all-zero and all-one values
        send(16'h0000, 16'hFFFF, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b0);
        for (int i = 2; i < 65; i++) send(16'($urandom), 16'($urandom), 1'b0);
        idle(3);

        // Frame start without valid is ignored, then a mid-frame restart at point 20
        i_frame_start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        i_frame_start = 1'b0;
        send(16'h1234, 16'h4321, 1'b1);
        for (int i = 1; i < 25; i++) send(16'($urandom), 16'($urandom), i == 20);
        idle(2);

        // Backpressure: three stalled cycles with a sample waiting behind
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(16'hA5A5, 16'h5A5A, 1'b0);
        fork
            send(16'h0F0F, 16'hF0F0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #3;
                rdy_force = 1'b1;
            end
        join
        send(16'h1111, 16'h2222, 1'b0);
        idle(3);

        // Reset while holding the sample at index 37
        send(16'h0001, 16'h0002, 1'b1);
        for (int i = 1; i < 38; i++) send(16'($urandom), 16'($urandom), 1'b0);
        i_valid = 1'b0;
        check("pre_reset_index", 32'(o_index), 32'd37);
        rst_n = 1'b0;
        #1;
        check("mid_reset_o_valid", 32'(o_valid), 32'd0);
        check("mid_reset_o_re", o_re, 32'd0);
        check("mid_reset_o_index", 32'(o_index), 32'd0);
        apply_reset();
        send(16'h7777, 16'h8888, 1'b0);
        idle(1);
        check("post_reset_index", 32'(o_index), 32'd0);
        idle(2);

        // Random traffic with random backpressure and occasional frame restarts
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(16'($urandom), 16'($urandom), $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        rdy_rand = 1'b0;
        rdy_force = 1'b1;

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("outputs_seen_nonzero", 32'(n_out > 500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_adj_16b_to_32b.md
BIT_ADJ_16B_TO_32B -- requirements
Module: bit_adj_16b_to_32b

Interface
REQ-001 The block SHALL have one clock, clk (input, 1 bit), and all state SHALL be updated on its rising edge.
REQ-002 The block SHALL have an asynchronous, active-low reset, rst_n (input, 1 bit).
REQ-003 Port i_valid (input, 1 bit): an input sample is offered.
REQ-004 Port o_ready (output, 1 bit): the block can accept an input sample this cycle.
REQ-005 Port i_re (input, 16 bits): real part, signed two's complement, 16-bit internal format.
REQ-006 Port i_im (input, 16 bits): imaginary part, same format as i_re.
REQ-007 Port i_frame_start (input, 1 bit): the offered sample is point 0 of a new 64-point frame.
REQ-008 Port o_valid (output, 1 bit): an output sample is presented.
REQ-009 Port i_ready (input, 1 bit): downstream accepts the output sample.
REQ-010 Port o_re (output, 32 bits): widened real part.
REQ-011 Port o_im (output, 32 bits): widened imaginary part.
REQ-012 Port o_index (output, 6 bits): point index of the output sample within its frame.
REQ-013 Port o_last (output, 1 bit): asserted when o_index equals 63.

Function
REQ-014 An input transfer SHALL occur when i_valid and o_ready are both 1; an output transfer SHALL occur when o_valid and i_ready are both 1.
REQ-015 Widening SHALL be computed per component as out[31:28] = 4 copies of in[15], out[27:12] = in[15:0], and out[11:0] = 0, matching the 32-bit word layout consumed by the 32-to-16 reducer.
REQ-016 The block SHALL be a single registered stage: data accepted in cycle N SHALL appear on the outputs with o_valid = 1 in cycle N+1.
REQ-017 o_ready SHALL equal (not o_valid) or i_ready, so the block sustains one sample per cycle under continuous i_ready.
REQ-018 While o_valid = 1 and i_ready = 0, o_re, o_im, o_index and o_last SHALL hold stable.
REQ-019 If an output transfer and an input transfer occur in the same cycle, the new sample SHALL be loaded and o_valid SHALL remain 1.
REQ-020 If an output transfer occurs with no input transfer, o_valid SHALL go to 0 in the next cycle.
REQ-021 A 6-bit point counter SHALL assign an index to each accepted sample.
- i_frame_start = 1: index 0; counter becomes 1.
- otherwise: index = counter; counter increments, wrapping from 63 to 0.
REQ-022 The counter SHALL change only on an input transfer; i_frame_start without i_valid SHALL be ignored.
REQ-023 o_last SHALL be registered together with o_index.

Reset
REQ-024 Asserting rst_n low SHALL immediately force:
- o_valid = 0
- counter = 0
- o_re, o_im, o_index = 0
- o_last = 0
REQ-025 A sample held at the output when reset is asserted mid-frame SHALL be discarded, and the first sample after reset SHALL receive index 0.
REQ-026 o_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Structure
REQ-027 The shared package SHALL contain the following constants:
- DATA_W_NARROW = 16
- DATA_W_WIDE = 32
- FRAC_SHIFT = 12
- GUARD_BITS = 4
- FFT_POINTS = 64
- IDX_W = 6
REQ-028 Combinational widening SHALL be placed in one sub-module, bit_widen_16b_to_32b, instantiated once per component.

Verification
REQ-029 Reset, then i_re = 16'h7FFF, i_im = 16'h8000 with i_frame_start = 1 and i_ready = 1 -> the next cycle shows o_re = 32'h07FFF000, o_im = 32'hF8000000, o_index = 0, o_valid = 1.
REQ-030 Stream 64 consecutive samples with i_frame_start on the first only -> o_index runs 0..63, o_last is 1 only at index 63, and the 65th sample gets index 0.
REQ-031 Hold i_ready = 0 for 3 cycles with valid output data -> outputs stay stable, o_ready = 0, and no sample is lost or duplicated after i_ready returns to 1.
REQ-032 Send random values through this block and then through the 32-to-16 reducer -> the reducer output equals the original 16-bit input for all values, including 16'h0000 and 16'hFFFF.
REQ-033 Assert i_frame_start at point 20 mid-frame -> that sample gets index 0, and the next gets index 1.
REQ-034 Assert rst_n low while o_valid = 1 at index 37 -> o_valid = 0 immediately, and the first sample after reset gets index 0.
